// File: rtl/digit_serial_adder.sv
// Digit-serial unsigned adder: one 3-bit slice reused per clock, carry held in a register.
// Optional saturation on final carry when DIGIT_SERIAL_ADDER_SAT_EN is defined.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// RUN   | adding digit k per cycle, operands frozen
// DONE  | result held, out_valid high until out_ready
module digit_serial_adder #(
   parameter int WIDTH = 12
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);
   localparam int NDIG = WIDTH / 3;
   localparam int KW   = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam logic [KW-1:0] KLAST = KW'(NDIG - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] a_q, b_q, sum_q;
   logic             carry_q, cout_q;
   logic [KW-1:0]    k_q;
   logic [2:0]       a_dig, b_dig;
   logic [3:0]       t;
   logic             accept, last;

   assign a_dig  = a_q[3*k_q +: 3];
   assign b_dig  = b_q[3*k_q +: 3];
   assign t      = {1'b0, a_dig} + {1'b0, b_dig} + {3'b000, carry_q};
   assign last   = (k_q == KLAST);
   assign accept = (state == IDLE) && in_valid;
   assign sum    = sum_q;
   assign cout   = cout_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = RUN;
         end
         RUN: begin
            if (last) state_nxt = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Slices not yet reached in RUN keep whatever the previous operation left there.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         k_q     <= '0;
      end else if (accept) begin
         a_q     <= a;
         b_q     <= b;
         carry_q <= cin;
         k_q     <= '0;
      end else if (state == RUN) begin
         sum_q[3*k_q +: 3] <= t[2:0];
         carry_q           <= t[3];
         k_q               <= k_q + 1'b1;
         if (last) begin
            cout_q <= t[3];
`ifdef DIGIT_SERIAL_ADDER_SAT_EN
            if (t[3]) sum_q <= '1;
`else
`endif
         end
      end
   end

endmodule

// File: tb/tb_digit_serial_adder.sv
// Directed bench for digit_serial_adder (WIDTH=12): vector table plus backpressure,
// mid-run reset and back-to-back sequences.
module tb_digit_serial_adder;
   localparam int WIDTH = 12;
   localparam int NDIG  = WIDTH / 3;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] a = '0;
   logic [WIDTH-1:0] b = '0;
   logic             cin = 1'b0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [WIDTH-1:0] sum;
   logic             cout;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   typedef struct {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic             cin;
      logic [WIDTH-1:0] sum;
      logic             cout;
   } vec_t;

   vec_t vecs[8];

   digit_serial_adder #(.WIDTH(WIDTH)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [WIDTH-1:0] exp_sum(input logic [WIDTH-1:0] s, input logic c);
`ifdef DIGIT_SERIAL_ADDER_SAT_EN
      return c ? {WIDTH{1'b1}} : s;
`else
      return s;
`endif
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One complete operation with out_ready low until the result is seen.
   task automatic run_op(input string tag, input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                         input logic vc, input logic [WIDTH-1:0] es, input logic ec);
      a = va; b = vb; cin = vc; in_valid = 1'b1; out_ready = 1'b0;
      check({tag, " in_ready before accept"}, in_ready, 1);
      step();
      in_valid = 1'b0;
      for (int i = 1; i < NDIG; i++) step();
      check({tag, " out_valid early"}, out_valid, 0);
      step();
      check({tag, " out_valid at latency"}, out_valid, 1);
      check({tag, " in_ready in DONE"}, in_ready, 0);
      check({tag, " sum"}, sum, exp_sum(es, ec));
      check({tag, " cout"}, cout, ec);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check({tag, " out_valid after handshake"}, out_valid, 0);
      check({tag, " in_ready after handshake"}, in_ready, 1);
   endtask

   initial begin
      logic [WIDTH-1:0] bb_a[3], bb_b[3], bb_s[3];
      logic             bb_c[3], bb_co[3];
      int               acc[3];
      int               bad;
      bit               seen;

      vecs[0] = '{12'h123, 12'h456, 1'b0, 12'h579, 1'b0};
      vecs[1] = '{12'h007, 12'h001, 1'b0, 12'h008, 1'b0};
      vecs[2] = '{12'h1FF, 12'h001, 1'b0, 12'h200, 1'b0};
      vecs[3] = '{12'hFFF, 12'h001, 1'b0, 12'h000, 1'b1};
      vecs[4] = '{12'hFFF, 12'hFFF, 1'b1, 12'hFFF, 1'b1};
      vecs[5] = '{12'h000, 12'h000, 1'b1, 12'h001, 1'b0};
      vecs[6] = '{12'hABC, 12'h123, 1'b0, 12'hBDF, 1'b0};
      vecs[7] = '{12'h800, 12'h800, 1'b0, 12'h000, 1'b1};

      bb_a = '{12'h001, 12'h7FF, 12'h555};
      bb_b = '{12'h002, 12'h801, 12'h2AA};
      bb_c = '{1'b0, 1'b0, 1'b1};
      bb_s = '{12'h003, 12'h000, 12'h800};
      bb_co = '{1'b0, 1'b1, 1'b0};

      step(); step();
      check("reset in_ready", in_ready, 1);
      check("reset out_valid", out_valid, 0);
      rst = 1'b0;
      step();
      check("reset sum", sum, 0);
      check("reset cout", cout, 0);
      check("idle in_ready", in_ready, 1);

      for (int i = 0; i < 8; i++) begin
         run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sum, vecs[i].cout);
      end

      // Backpressure with a competing in_valid held through RUN and DONE.
      a = 12'h123; b = 12'h456; cin = 1'b0; in_valid = 1'b1;
      step();
      a = 12'h111; b = 12'h222; cin = 1'b1;
      for (int i = 1; i <= NDIG; i++) step();
      check("bp out_valid", out_valid, 1);
      for (int i = 0; i < 6; i++) begin
         step();
         check($sformatf("bp hold%0d out_valid", i), out_valid, 1);
         check($sformatf("bp hold%0d sum", i), sum, 12'h579);
         check($sformatf("bp hold%0d cout", i), cout, 0);
         check($sformatf("bp hold%0d in_ready", i), in_ready, 0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("bp release in_ready", in_ready, 1);
      check("bp release out_valid", out_valid, 0);
      step();
      check("bp no phantom accept", in_ready, 1);

      // Reset while k==2 in RUN.
      a = 12'hFFF; b = 12'h001; cin = 1'b0; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step(); step();
      rst = 1'b1;
      #1;
      check("rst mid in_ready", in_ready, 1);
      check("rst mid out_valid", out_valid, 0);
      check("rst mid sum", sum, 0);
      check("rst mid cout", cout, 0);
      step();
      rst = 1'b0;
      bad = 0;
      for (int i = 0; i < NDIG + 3; i++) begin
         step();
         if (out_valid) bad++;
      end
      check("rst no out_valid pulse", bad, 0);
      run_op("post-rst", 12'h00A, 12'h005, 1'b0, 12'h00F, 1'b0);

      // Back-to-back with out_ready tied high.
      out_ready = 1'b1;
      for (int j = 0; j < 3; j++) begin
         a = bb_a[j]; b = bb_b[j]; cin = bb_c[j]; in_valid = 1'b1;
         seen = 0;
         for (int w = 0; w < 10 && !seen; w++) begin
            if (in_ready) seen = 1;
            else step();
         end
         check($sformatf("b2b%0d in_ready seen", j), seen, 1);
         step();
         acc[j] = cyc;
         seen = 0;
         for (int w = 0; w < 10 && !seen; w++) begin
            step();
            if (out_valid) seen = 1;
         end
         check($sformatf("b2b%0d out_valid seen", j), seen, 1);
         check($sformatf("b2b%0d latency", j), cyc - acc[j], NDIG);
         check($sformatf("b2b%0d sum", j), sum, exp_sum(bb_s[j], bb_co[j]));
         check($sformatf("b2b%0d cout", j), cout, bb_co[j]);
         if (j > 0) check($sformatf("b2b%0d spacing", j), acc[j] - acc[j-1], NDIG + 2);
      end
      in_valid = 1'b0;
      step(); step();
      check("b2b final idle", in_ready, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end
endmodule

// File: doc/digit_serial_adder.md
Name: digit_serial_adder

Overview:
- Multi-cycle unsigned adder that processes WIDTH-bit operands as 3-bit digits, least significant digit first, one digit per clock.
- One combinational 3-bit-plus-carry slice is reused each cycle, with the carry held in a register between digits.
- Sits between the MAC partial-product stage and the accumulator writeback; valid/ready handshakes on both sides.
- Trades latency for area compared with a full-width lookahead adder.

Parameters:
- WIDTH, 12, operand and sum width in bits; must be a multiple of 3 and at least 3.
- NDIG, WIDTH/3, digit count; derived, not overridable.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-high.
- in_valid  in  1  operands a, b, cin are valid.
- in_ready  out  1  block can accept an operation.
- a  in  WIDTH  operand A, unsigned.
- b  in  WIDTH  operand B, unsigned.
- cin  in  1  carry into digit 0.
- out_valid  out  1  sum and cout are valid.
- out_ready  in  1  consumer accepts the result.
- sum  out  WIDTH  A+B+cin modulo 2^WIDTH.
- cout  out  1  carry out of the most significant digit.

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE, in_ready=1, out_valid=0, sum=0, cout=0.
  - Digit counter and carry register cleared.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch a, b; load the carry register with cin; digit counter k=0; go to RUN.
- RUN:
  - in_ready=0; in_valid is ignored and operands are not re-sampled.
  - Each cycle: t[3:0] = a[3k+2:3k] + b[3k+2:3k] + carry.
  - Write sum[3k+2:3k] <= t[2:0]; carry <= t[3]; k <= k+1.
  - When k==NDIG-1: go to DONE and set cout <= t[3].
- DONE:
  - out_valid=1; sum and cout held stable.
  - On out_ready: out_valid deasserts next cycle; go to IDLE.
  - With out_ready low, hold indefinitely. in_ready=0.
- Latency: the accept edge is edge 0; out_valid is high after edge NDIG (e.g. 4 cycles for WIDTH=12).
- Minimum spacing between accepts: NDIG+2 cycles.
- Digit slices of sum not yet computed may hold stale values in RUN; only DONE values are defined.
- Carry chain spans digits only through the carry register; no combinational path from a/b to sum/cout.
- out_valid and in_ready are never both high.
- rst asserted in any state, including mid-RUN, aborts the operation immediately; the result is discarded and no out_valid pulse follows.

Optional Feature:
- Macro: DIGIT_SERIAL_ADDER_SAT_EN.
- Defined:
  - On entering DONE with final carry=1, sum is forced to all ones (2^WIDTH-1); cout still reports 1.
  - The forcing happens on the same edge that enters DONE; out_valid timing is unchanged.
- Undefined: sum wraps modulo 2^WIDTH; no saturation logic is present.

Test Plan:
- WIDTH=12, a=0x123, b=0x456, cin=0 -> after 4 cycles out_valid=1, sum=0x579, cout=0.
- a=0x007, b=0x001, cin=0 -> sum=0x008, cout=0 (carry crosses digits 0 to 1). a=0x1FF, b=0x001 -> sum=0x200.
- a=0xFFF, b=0x001, cin=0 -> sum=0x000, cout=1. With DIGIT_SERIAL_ADDER_SAT_EN defined -> sum=0xFFF, cout=1. a=0xFFF, b=0xFFF, cin=1 -> sum=0xFFF, cout=1 (no macro).
- Backpressure: hold out_ready=0 for 6 cycles in DONE -> sum/cout stable, in_ready=0; in_valid pulsed during RUN/DONE is not accepted; out_ready=1 -> IDLE and in_ready=1 next cycle.
- Assert rst for 1 cycle at RUN k=2 -> all outputs at reset values immediately; no out_valid; a new op a=0x00A, b=0x005 then yields sum=0x00F.
- Back-to-back: three ops with out_ready tied 1 -> results in order, each accept spaced 6 cycles (WIDTH=12).
